// File: rtl/mc_controller.sv
// Multicycle control FSM for a small MIPS-style core.
// Moore outputs registered from next state; pcen/irwrite/illegal gated by inputs.
module mc_controller #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [5:0]   op,
  input  logic         zero,
  input  logic         mem_ready,
  output logic [1:0]   aluop,
  output logic         iord,
  output logic         irwrite,
  output logic         memwrite,
  output logic         regwrite,
  output logic         regdst,
  output logic         memtoreg,
  output logic         alusrca,
  output logic         pcen,
  output logic         illegal,
  output logic [1:0]   alusrcb,
  output logic [1:0]   pcsrc,
  output logic [3:0]   state,
  output logic [n-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BEQ     = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    BNE     = 4'd12
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       fetch;
    logic       decode;
    logic       beq;
    logic       bne;
    logic       jump;
  } ctl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t st;
  state_t nxt;
  ctl_t   c;
  logic   is_r, is_lw, is_sw, is_beq, is_bne, is_addi, is_j;
  logic   legal;
  logic   retire;

  assign is_r    = (op == OP_R);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_addi = (op == OP_ADDI);
  assign is_j    = (op == OP_J);
  assign legal   = is_r | is_lw | is_sw | is_beq
                 | is_bne | is_addi | is_j;

  function automatic ctl_t ctl_of(state_t s);
    ctl_t k;
    k = '0;
    case (s)
      FETCH: begin
        k.alusrcb = 2'b01;
        k.fetch   = 1'b1;
      end
      DECODE: begin
        k.alusrcb = 2'b11;
        k.decode  = 1'b1;
      end
      MEMADR: begin
        k.alusrca = 1'b1;
        k.alusrcb = 2'b10;
      end
      MEMRD: k.iord = 1'b1;
      MEMWB: begin
        k.memtoreg = 1'b1;
        k.regwrite = 1'b1;
      end
      MEMWR: begin
        k.iord     = 1'b1;
        k.memwrite = 1'b1;
      end
      EXECUTE: begin
        k.alusrca = 1'b1;
        k.aluop   = 2'b10;
      end
      ALUWB: begin
        k.regdst   = 1'b1;
        k.regwrite = 1'b1;
      end
      BEQ: begin
        k.alusrca = 1'b1;
        k.aluop   = 2'b01;
        k.pcsrc   = 2'b01;
        k.beq     = 1'b1;
      end
      ADDIEX: begin
        k.alusrca = 1'b1;
        k.alusrcb = 2'b10;
      end
      ADDIWB: k.regwrite = 1'b1;
      JUMP: begin
        k.pcsrc = 2'b10;
        k.jump  = 1'b1;
      end
      BNE: begin
        k.alusrca = 1'b1;
        k.aluop   = 2'b11;
        k.pcsrc   = 2'b01;
        k.bne     = 1'b1;
      end
      default: k = '0;
    endcase
    return k;
  endfunction

  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH:   nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: nxt = MEMADR;
          is_r:         nxt = EXECUTE;
          is_beq:       nxt = BEQ;
          is_bne:       nxt = BNE;
          is_addi:      nxt = ADDIEX;
          is_j:         nxt = JUMP;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:  nxt = is_sw ? MEMWR : MEMRD;
      MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
      EXECUTE: nxt = ALUWB;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  // Every transition back to FETCH except the illegal-opcode path retires.
  always_comb begin
    retire = 1'b0;
    case (st)
      MEMWB, ALUWB, ADDIWB,
      BEQ, BNE, JUMP: retire = 1'b1;
      MEMWR:          retire = mem_ready;
      default:        retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= FETCH;
      c       <= ctl_of(FETCH);
      instret <= '0;
    end else begin
      st <= nxt;
      c  <= ctl_of(nxt);
      if (retire)
        instret <= instret + 1'b1;
    end
  end

  assign state    = st;
  assign aluop    = c.aluop;
  assign iord     = c.iord;
  assign memwrite = c.memwrite;
  assign regwrite = c.regwrite;
  assign regdst   = c.regdst;
  assign memtoreg = c.memtoreg;
  assign alusrca  = c.alusrca;
  assign alusrcb  = c.alusrcb;
  assign pcsrc    = c.pcsrc;
  assign illegal  = c.decode & ~legal;
  assign irwrite  = reset & c.fetch & mem_ready;
  assign pcen     = reset & ((c.fetch & mem_ready)
                  | (c.beq & zero)
                  | (c.bne & ~zero)
                  | c.jump);

endmodule
